// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit pair: state encoding,
// frame width and the baud tick divider calculation.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Rounded clocks-per-tick: round(clk_hz / (baud * os)).
  function automatic int calc_tick_div(input int clk_hz, input int baud, input int os);
    longint denom;
    longint result;
    denom  = longint'(baud) * longint'(os);
    result = (longint'(clk_hz) + denom / 2) / denom;
    return int'(result);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle tick every TICK_DIV clocks,
// restartable so a new frame aligns its sample grid to the detected start edge.
module uart_baud_tick #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("uart_baud_tick: TICK_DIV must be at least 1");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx_i, oversamples each bit, validates the
// start/stop bits and presents completed bytes on a valid/ready interface.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int OVERSAMPLE  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_i,
  output logic [7:0]      out_byte,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            framing_err,
  output logic            overrun_err,
  output logic            busy,
  output rx_state_t       state_o
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int SCW      = $clog2(OVERSAMPLE);
  localparam int BW       = $clog2(DATA_BITS);

  localparam logic [SCW-1:0] SC_MID   = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST  = SCW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("uart_rx: CLK_FREQ_HZ too low for BAUD*OVERSAMPLE (TICK_DIV = 0)");
  end
  if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
    $error("uart_rx: OVERSAMPLE must be even and at least 4");
  end

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 rx_s;

  rx_state_t            state_q, state_d;
  logic [SCW-1:0]       sc_q, sc_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;

  logic [7:0]           out_byte_q, out_byte_d;
  logic                 out_valid_q, out_valid_d;
  logic                 framing_q, framing_d;
  logic                 overrun_q, overrun_d;

  logic                 tick;
  logic                 restart;
  logic                 byte_done;
  logic                 frame_bad;

  assign rx_s = sync2_q;

  uart_baud_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  // Frame FSM. Start is confirmed at mid-bit; data and stop are sampled one
  // full bit period apart from there, i.e. near the centre of each bit.
  always_comb begin
    state_d   = state_q;
    sc_d      = sc_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    restart   = 1'b0;
    byte_done = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          sc_d    = '0;
          restart = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (sc_q == SC_MID) begin
            sc_d  = '0;
            bit_d = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (sc_q == SC_LAST) begin
            sc_d    = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (sc_q == SC_LAST) begin
            sc_d = '0;
            if (rx_s) begin
              byte_done = 1'b1;
              state_d   = IDLE;
            end else begin
              frame_bad = 1'b1;
              state_d   = BREAK;
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake: out_byte/out_valid hold until a cycle with out_valid && out_ready.
  // A byte completing in that same cycle replaces the accepted one; completing
  // while the holder is full and not being accepted drops the new byte (overrun).
  always_comb begin
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;
    framing_d   = frame_bad;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (byte_done) begin
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end else begin
        out_byte_d  = shift_q;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sc_q        <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      framing_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sc_q        <= sc_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      framing_q   <= framing_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_byte    = out_byte_q;
  assign out_valid   = out_valid_q;
  assign framing_err = framing_q;
  assign overrun_err = overrun_q;
  assign busy        = (state_q != IDLE);
  assign state_o     = state_q;

endmodule
